// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//
// Multi-cycle control FSM for the 19-bit instruction datapath. Each
// instruction walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The block
// drives the datapath mux selects and enables, and handshakes with the
// instruction and data memories. It also sequences branches, jumps and
// HALT, and times out a stalled memory handshake.
//
// Ports:
//   clock, rst          clock; synchronous active-high reset
//   imem_ready, instr   instruction memory handshake and instruction word
//   dmem_ready          data memory finished the read/write this cycle
//   zero_in, carry_in   current Zero/Carry flag register values
//   imem_req, ir_load   fetch request; latch instr into IR
//   alu_fn, sh_ro_fn    ALU / shift-rotate function codes taken from IR
//   sel_alu_arg         1 = register operand, 0 = immediate
//   sel_r2              1 = IR[7:5], 0 = IR[13:11] (STM data register)
//   sel_to_write        00 ALU, 01 shift/rotate, 10 data memory
//   enable_zero/carry   flag register write enables
//   reg_write           register file write enable
//   mem_read/mem_write  data memory strobes
//   pc_en, pc_sel       PC update; 00 PC+1, 01 branch, 10 jump, 11 return
//   stack_push/pop      return-address stack controls
//   halted, err         HALT executed; sticky error (illegal op / timeout)
//
// Optional build macro CTRL_PERF_CNT_EN adds retired_count[15:0] (cycles
// with pc_en=1) and stall_count[15:0] (FETCH/MEM cycles without ready).
// Both wrap. Without the macro those ports and counters do not exist.
//
// All outputs decode the registered state and IR opcode fields, plus the
// current-cycle ready and flag inputs where the handshake or branch test
// needs them. Every output is forced low while rst is high.

module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        imem_ready,
    input  logic [18:0] instr,
    input  logic        dmem_ready,
    input  logic        zero_in,
    input  logic        carry_in,
    output logic        imem_req,
    output logic        ir_load,
    output logic [2:0]  alu_fn,
    output logic [1:0]  sh_ro_fn,
    output logic        sel_alu_arg,
    output logic        sel_r2,
    output logic [1:0]  sel_to_write,
    output logic        enable_zero,
    output logic        enable_carry,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic        stack_push,
    output logic        stack_pop,
    output logic        halted,
    output logic        err
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [15:0] retired_count,
    output logic [15:0] stall_count
`endif
);

    // One spare bit so the count can never wrap before the limit is seen.
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1) + 1;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALTED,
        S_ERR
    } state_t;

    state_t             state_reg;
    // Only the opcode/function bits IR[18:14] steer this block. Register
    // and immediate fields go to the datapath's own copy of IR.
    logic [4:0]         ir_op_reg;
    logic [CNT_W-1:0]   wait_cnt_reg;

    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[13:0];

    // Opcode decode
    logic       is_alu, is_alu_reg, is_shift, is_mem, is_ldm, is_branch, is_ctrl;
    logic       illegal_op, branch_taken, wait_expired;
    logic [1:0] fn;

    assign fn         = ir_op_reg[1:0];
    assign is_alu     = (ir_op_reg[4] == 1'b0);
    assign is_alu_reg = (ir_op_reg[4:3] == 2'b00);
    assign is_shift   = (ir_op_reg[4:2] == 3'b110);
    assign is_mem     = (ir_op_reg[4:2] == 3'b100);
    assign is_ldm     = is_mem && (fn == 2'b00);
    assign is_branch  = (ir_op_reg[4:2] == 3'b101);
    assign is_ctrl    = (ir_op_reg[4:2] == 3'b111);
    // Memory class with fn 10/11 is the only unassigned encoding.
    assign illegal_op = is_mem && fn[1];

    always_comb begin
        case (fn)
            2'b00:   branch_taken = zero_in;
            2'b01:   branch_taken = ~zero_in;
            2'b10:   branch_taken = carry_in;
            default: branch_taken = ~carry_in;
        endcase
    end

    // A ready seen while the count equals MEM_TIMEOUT is still accepted.
    // Only a miss at that point moves the FSM to ERR.
    assign wait_expired = (wait_cnt_reg >= CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge clock) begin
        if (rst) begin
            state_reg    <= S_FETCH;
            ir_op_reg    <= '0;
            wait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir_op_reg    <= instr[18:14];
                        wait_cnt_reg <= '0;
                        state_reg    <= S_DECODE;
                    end else if (wait_expired) begin
                        state_reg <= S_ERR;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    wait_cnt_reg <= '0;
                    state_reg    <= illegal_op ? S_ERR : S_EXEC;
                end
                S_EXEC: begin
                    wait_cnt_reg <= '0;
                    if (is_alu || is_shift)
                        state_reg <= S_WB;
                    else if (is_mem)
                        state_reg <= S_MEM;
                    else if (is_ctrl && fn == 2'b11)
                        state_reg <= S_HALTED;
                    else
                        state_reg <= S_FETCH;
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        wait_cnt_reg <= '0;
                        state_reg    <= is_ldm ? S_WB : S_FETCH;
                    end else if (wait_expired) begin
                        state_reg <= S_ERR;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                    end
                end
                S_WB: begin
                    wait_cnt_reg <= '0;
                    state_reg    <= S_FETCH;
                end
                S_HALTED: state_reg <= S_HALTED;
                S_ERR:    state_reg <= S_ERR;
                default:  state_reg <= S_ERR;
            endcase
        end
    end

    always_comb begin
        imem_req     = 1'b0;
        ir_load      = 1'b0;
        alu_fn       = 3'b000;
        sh_ro_fn     = 2'b00;
        sel_alu_arg  = 1'b0;
        sel_r2       = 1'b0;
        sel_to_write = 2'b00;
        enable_zero  = 1'b0;
        enable_carry = 1'b0;
        reg_write    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        pc_en        = 1'b0;
        pc_sel       = 2'b00;
        stack_push   = 1'b0;
        stack_pop    = 1'b0;
        halted       = 1'b0;
        err          = 1'b0;
        if (!rst) begin
            case (state_reg)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_load  = imem_ready;
                end
                S_EXEC: begin
                    if (is_alu) begin
                        alu_fn       = ir_op_reg[2:0];
                        sel_alu_arg  = ~ir_op_reg[3];
                        sel_r2       = is_alu_reg;
                        enable_zero  = 1'b1;
                        enable_carry = 1'b1;
                    end else if (is_shift) begin
                        sh_ro_fn     = fn;
                        sel_to_write = 2'b01;
                    end else if (is_branch) begin
                        pc_en  = 1'b1;
                        pc_sel = branch_taken ? 2'b01 : 2'b00;
                    end else if (is_ctrl) begin
                        case (fn)
                            2'b00: begin
                                pc_en  = 1'b1;
                                pc_sel = 2'b10;
                            end
                            2'b01: begin
                                pc_en      = 1'b1;
                                pc_sel     = 2'b10;
                                stack_push = 1'b1;
                            end
                            2'b10: begin
                                pc_en     = 1'b1;
                                pc_sel    = 2'b11;
                                stack_pop = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MEM: begin
                    // Strobes stay up through the cycle that dmem_ready arrives.
                    if (is_ldm) begin
                        mem_read = 1'b1;
                    end else begin
                        mem_write = 1'b1;
                        sel_r2    = 1'b0;
                        if (dmem_ready) begin
                            pc_en  = 1'b1;
                            pc_sel = 2'b00;
                        end
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    pc_en     = 1'b1;
                    pc_sel    = 2'b00;
                    if (is_ldm) begin
                        sel_to_write = 2'b10;
                    end else if (is_shift) begin
                        sel_to_write = 2'b01;
                        sh_ro_fn     = fn;
                    end else begin
                        // The ALU is combinational, so its operand and
                        // function selects stay up until the result is written.
                        alu_fn      = ir_op_reg[2:0];
                        sel_alu_arg = ~ir_op_reg[3];
                        sel_r2      = is_alu_reg;
                    end
                end
                S_HALTED: halted = 1'b1;
                S_ERR:    err    = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic stall_cycle;
    assign stall_cycle = ((state_reg == S_FETCH) && !imem_ready) ||
                         ((state_reg == S_MEM) && !dmem_ready);

    always_ff @(posedge clock) begin
        if (rst) begin
            retired_count <= '0;
            stall_count   <= '0;
        end else begin
            if (pc_en)
                retired_count <= retired_count + 16'd1;
            if (stall_cycle)
                stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Testbench for multicycle_sequencer (default build, MEM_TIMEOUT = 15).
// Each scenario task queues per-cycle stimulus with the outputs expected in
// that cycle. The expectation goes into a scoreboard as the stimulus is
// driven. It is popped and compared at the following falling edge.

module tb_multicycle_sequencer;

    logic        clock;
    logic        rst;
    logic        imem_ready;
    logic [18:0] instr;
    logic        dmem_ready;
    logic        zero_in;
    logic        carry_in;
    logic        imem_req, ir_load;
    logic [2:0]  alu_fn;
    logic [1:0]  sh_ro_fn;
    logic        sel_alu_arg, sel_r2;
    logic [1:0]  sel_to_write;
    logic        enable_zero, enable_carry, reg_write, mem_read, mem_write, pc_en;
    logic [1:0]  pc_sel;
    logic        stack_push, stack_pop, halted, err;

    multicycle_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clock(clock), .rst(rst), .imem_ready(imem_ready), .instr(instr),
        .dmem_ready(dmem_ready), .zero_in(zero_in), .carry_in(carry_in),
        .imem_req(imem_req), .ir_load(ir_load), .alu_fn(alu_fn),
        .sh_ro_fn(sh_ro_fn), .sel_alu_arg(sel_alu_arg), .sel_r2(sel_r2),
        .sel_to_write(sel_to_write), .enable_zero(enable_zero),
        .enable_carry(enable_carry), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .pc_en(pc_en),
        .pc_sel(pc_sel), .stack_push(stack_push), .stack_pop(stack_pop),
        .halted(halted), .err(err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       imem_req;
        logic       ir_load;
        logic [2:0] alu_fn;
        logic [1:0] sh_ro_fn;
        logic       sel_alu_arg;
        logic       sel_r2;
        logic [1:0] sel_to_write;
        logic       enable_zero;
        logic       enable_carry;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       pc_en;
        logic [1:0] pc_sel;
        logic       stack_push;
        logic       stack_pop;
        logic       halted;
        logic       err;
    } out_t;

    typedef struct {
        logic        rst;
        logic        imem_ready;
        logic [18:0] instr;
        logic        dmem_ready;
        logic        zero_in;
        logic        carry_in;
        out_t        val;
        out_t        care;
    } step_t;

    typedef struct {
        out_t val;
        out_t care;
    } sb_t;

    out_t outs;
    assign outs = '{imem_req, ir_load, alu_fn, sh_ro_fn, sel_alu_arg, sel_r2,
                    sel_to_write, enable_zero, enable_carry, reg_write,
                    mem_read, mem_write, pc_en, pc_sel, stack_push,
                    stack_pop, halted, err};

    step_t plan_q[$];
    sb_t   exp_q[$];
    int    checks = 0;
    int    errors = 0;

    // Instruction encodings (register/immediate fields left at zero)
    localparam logic [18:0] I_ALU_IMM = 19'b01_010_00000000000000;
    localparam logic [18:0] I_SHIFT   = 19'b110_10_00000000000000;
    localparam logic [18:0] I_LDM     = 19'b100_00_00000000000000;
    localparam logic [18:0] I_STM     = 19'b100_01_00000000000000;
    localparam logic [18:0] I_ILLEGAL = 19'b100_10_00000000000000;
    localparam logic [18:0] I_JMP     = 19'b111_00_00000000000000;
    localparam logic [18:0] I_JSR     = 19'b111_01_00000000000000;
    localparam logic [18:0] I_RET     = 19'b111_10_00000000000000;
    localparam logic [18:0] I_HALT    = 19'b111_11_00000000000000;

    out_t care_all, care_ex, care_wb;

    function automatic out_t o_none();
        out_t o;
        o = '0;
        return o;
    endfunction

    function automatic out_t o_fetch(input logic rdy);
        out_t o;
        o = '0;
        o.imem_req = 1'b1;
        o.ir_load  = rdy;
        return o;
    endfunction

    function automatic out_t o_pc(input logic [1:0] sel, input logic push, input logic pop);
        out_t o;
        o = '0;
        o.pc_en      = 1'b1;
        o.pc_sel     = sel;
        o.stack_push = push;
        o.stack_pop  = pop;
        return o;
    endfunction

    task automatic add(input logic r, input logic ir, input logic [18:0] ins,
                       input logic dr, input logic z, input logic c,
                       input out_t v, input out_t cm);
        step_t s;
        s.rst = r; s.imem_ready = ir; s.instr = ins; s.dmem_ready = dr;
        s.zero_in = z; s.carry_in = c; s.val = v; s.care = cm;
        plan_q.push_back(s);
    endtask

    // Drives one cycle of stimulus and records its expectation in the scoreboard.
    task automatic apply(input step_t s);
        sb_t e;
        rst        = s.rst;
        imem_ready = s.imem_ready;
        instr      = s.instr;
        dmem_ready = s.dmem_ready;
        zero_in    = s.zero_in;
        carry_in   = s.carry_in;
        e.val  = s.val;
        e.care = s.care;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        sb_t e;
        int n = 0;
        add(1, 1, I_JMP, 1, 1, 1, o_none(), care_all);
        add(1, 1, I_JMP, 1, 1, 1, o_none(), care_all);
        add(0, 0, '0, 0, 0, 0, o_fetch(0), care_all);
        while (plan_q.size() > 0) begin
            apply(plan_q.pop_front());
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ((outs & e.care) !== (e.val & e.care)) begin
                errors++;
                $display("FAIL test_reset step %0d: outputs %h required %h (mask %h)", n, outs, e.val, e.care);
            end
            @(posedge clock); #1;
            n++;
        end
        $display("test_reset: %0d cycles checked", n);
    endtask

    task automatic test_alu_shift();
        sb_t  e;
        out_t v;
        int   n = 0;
        // ALU immediate, fn 010
        add(0, 1, I_ALU_IMM, 0, 0, 0, o_fetch(1), care_all);
        add(0, 0, '0, 0, 0, 0, o_none(), care_all);
        v = '0; v.alu_fn = 3'b010; v.sel_alu_arg = 1'b0; v.sel_to_write = 2'b00;
        v.enable_zero = 1'b1; v.enable_carry = 1'b1;
        add(0, 0, '0, 0, 0, 0, v, care_ex);
        v = o_pc(2'b00, 0, 0); v.reg_write = 1'b1; v.sel_to_write = 2'b00;
        add(0, 0, '0, 0, 0, 0, v, care_wb);
        // Shift/rotate, fn 10
        add(0, 1, I_SHIFT, 0, 0, 0, o_fetch(1), care_all);
        add(0, 0, '0, 0, 0, 0, o_none(), care_all);
        v = '0; v.sh_ro_fn = 2'b10; v.sel_to_write = 2'b01;
        add(0, 0, '0, 0, 0, 0, v, care_ex);
        v = o_pc(2'b00, 0, 0); v.reg_write = 1'b1; v.sel_to_write = 2'b01;
        add(0, 0, '0, 0, 0, 0, v, care_wb);
        while (plan_q.size() > 0) begin
            apply(plan_q.pop_front());
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ((outs & e.care) !== (e.val & e.care)) begin
                errors++;
                $display("FAIL test_alu_shift step %0d: outputs %h required %h (mask %h)", n, outs, e.val, e.care);
            end
            @(posedge clock); #1;
            n++;
        end
        $display("test_alu_shift: %0d cycles checked", n);
    endtask

    task automatic test_mem();
        sb_t  e;
        out_t v;
        int   n = 0;
        // LDM, dmem_ready delayed 3 cycles: mem_read high for 4 cycles
        add(0, 1, I_LDM, 0, 0, 0, o_fetch(1), care_all);
        add(0, 0, '0, 0, 0, 0, o_none(), care_all);
        add(0, 0, '0, 0, 0, 0, o_none(), care_all);
        v = '0; v.mem_read = 1'b1;
        for (int i = 0; i < 4; i++)
            add(0, 0, '0, (i == 3), 0, 0, v, care_all);
        v = o_pc(2'b00, 0, 0); v.reg_write = 1'b1; v.sel_to_write = 2'b10;
        add(0, 0, '0, 0, 0, 0, v, care_all);
        // STM, dmem_ready immediately
        add(0, 1, I_STM, 0, 0, 0, o_fetch(1), care_all);
        add(0, 0, '0, 0, 0, 0, o_none(), care_all);
        add(0, 0, '0, 0, 0, 0, o_none(), care_all);
        v = o_pc(2'b00, 0, 0); v.mem_write = 1'b1; v.sel_r2 = 1'b0;
        add(0, 0, '0, 1, 0, 0, v, care_all);
        while (plan_q.size() > 0) begin
            apply(plan_q.pop_front());
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ((outs & e.care) !== (e.val & e.care)) begin
                errors++;
                $display("FAIL test_mem step %0d: outputs %h required %h (mask %h)", n, outs, e.val, e.care);
            end
            @(posedge clock); #1;
            n++;
        end
        $display("test_mem: %0d cycles checked", n);
    endtask

    task automatic test_branch();
        sb_t         e;
        logic [18:0] ins;
        logic [1:0]  fnv;
        logic        z, c, taken;
        int          n = 0;
        // {fn, zero, carry}: BZ z1, BZ z0, BNZ z0, BNZ z1, BC c1, BC c0, BNC c1, BNC c0
        logic [3:0]  tbl [8] = '{4'b00_1_0, 4'b00_0_1, 4'b01_0_0, 4'b01_1_1,
                                 4'b10_0_1, 4'b10_1_0, 4'b11_1_1, 4'b11_0_0};
        for (int k = 0; k < 8; k++) begin
            fnv = tbl[k][3:2]; z = tbl[k][1]; c = tbl[k][0];
            case (fnv)
                2'b00:   taken = z;
                2'b01:   taken = !z;
                2'b10:   taken = c;
                default: taken = !c;
            endcase
            ins = {3'b101, fnv, 14'd0};
            add(0, 1, ins, 0, z, c, o_fetch(1), care_all);
            add(0, 0, '0, 0, z, c, o_none(), care_all);
            add(0, 0, '0, 0, z, c, o_pc(taken ? 2'b01 : 2'b00, 0, 0), care_all);
        end
        while (plan_q.size() > 0) begin
            apply(plan_q.pop_front());
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ((outs & e.care) !== (e.val & e.care)) begin
                errors++;
                $display("FAIL test_branch step %0d: outputs %h required %h (mask %h)", n, outs, e.val, e.care);
            end
            @(posedge clock); #1;
            n++;
        end
        $display("test_branch: %0d cycles checked", n);
    endtask

    task automatic test_jsr_ret();
        sb_t e;
        int  n = 0;
        add(0, 1, I_JSR, 0, 0, 0, o_fetch(1), care_all);
        add(0, 0, '0, 0, 0, 0, o_none(), care_all);
        add(0, 0, '0, 0, 0, 0, o_pc(2'b10, 1, 0), care_all);
        add(0, 1, I_JMP, 0, 0, 0, o_fetch(1), care_all);
        add(0, 0, '0, 0, 0, 0, o_none(), care_all);
        add(0, 0, '0, 0, 0, 0, o_pc(2'b10, 0, 0), care_all);
        add(0, 1, I_RET, 0, 0, 0, o_fetch(1), care_all);
        add(0, 0, '0, 0, 0, 0, o_none(), care_all);
        add(0, 0, '0, 0, 0, 0, o_pc(2'b11, 0, 1), care_all);
        while (plan_q.size() > 0) begin
            apply(plan_q.pop_front());
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ((outs & e.care) !== (e.val & e.care)) begin
                errors++;
                $display("FAIL test_jsr_ret step %0d: outputs %h required %h (mask %h)", n, outs, e.val, e.care);
            end
            @(posedge clock); #1;
            n++;
        end
        $display("test_jsr_ret: %0d cycles checked", n);
    endtask

    // imem_ready arrives in the 16th FETCH cycle (count == MEM_TIMEOUT) and is accepted.
    task automatic test_fetch_wait_limit();
        sb_t e;
        int  n = 0;
        for (int i = 0; i < 15; i++)
            add(0, 0, '0, 0, 0, 0, o_fetch(0), care_all);
        add(0, 1, I_JMP, 0, 0, 0, o_fetch(1), care_all);
        add(0, 0, '0, 0, 0, 0, o_none(), care_all);
        add(0, 0, '0, 0, 0, 0, o_pc(2'b10, 0, 0), care_all);
        while (plan_q.size() > 0) begin
            apply(plan_q.pop_front());
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ((outs & e.care) !== (e.val & e.care)) begin
                errors++;
                $display("FAIL test_fetch_wait_limit step %0d: outputs %h required %h (mask %h)", n, outs, e.val, e.care);
            end
            @(posedge clock); #1;
            n++;
        end
        $display("test_fetch_wait_limit: %0d cycles checked", n);
    endtask

    task automatic test_mem_timeout();
        sb_t  e;
        out_t v;
        int   n = 0;
        add(0, 1, I_STM, 0, 0, 0, o_fetch(1), care_all);
        add(0, 0, '0, 0, 0, 0, o_none(), care_all);
        add(0, 0, '0, 0, 0, 0, o_none(), care_all);
        v = '0; v.mem_write = 1'b1;
        for (int i = 0; i < 16; i++)
            add(0, 0, '0, 0, 0, 0, v, care_all);
        v = '0; v.err = 1'b1;
        add(0, 1, I_JMP, 1, 0, 0, v, care_all);
        add(0, 1, I_JMP, 1, 0, 0, v, care_all);
        add(1, 0, '0, 0, 0, 0, o_none(), care_all);
        add(0, 0, '0, 0, 0, 0, o_fetch(0), care_all);
        while (plan_q.size() > 0) begin
            apply(plan_q.pop_front());
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ((outs & e.care) !== (e.val & e.care)) begin
                errors++;
                $display("FAIL test_mem_timeout step %0d: outputs %h required %h (mask %h)", n, outs, e.val, e.care);
            end
            @(posedge clock); #1;
            n++;
        end
        $display("test_mem_timeout: %0d cycles checked", n);
    endtask

    task automatic test_illegal();
        sb_t  e;
        out_t v;
        int   n = 0;
        add(0, 1, I_ILLEGAL, 0, 0, 0, o_fetch(1), care_all);
        add(0, 0, '0, 0, 0, 0, o_none(), care_all);
        v = '0; v.err = 1'b1;
        add(0, 1, I_JMP, 1, 0, 0, v, care_all);
        add(0, 1, I_JMP, 1, 0, 0, v, care_all);
        add(1, 0, '0, 0, 0, 0, o_none(), care_all);
        add(0, 0, '0, 0, 0, 0, o_fetch(0), care_all);
        while (plan_q.size() > 0) begin
            apply(plan_q.pop_front());
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ((outs & e.care) !== (e.val & e.care)) begin
                errors++;
                $display("FAIL test_illegal step %0d: outputs %h required %h (mask %h)", n, outs, e.val, e.care);
            end
            @(posedge clock); #1;
            n++;
        end
        $display("test_illegal: %0d cycles checked", n);
    endtask

    task automatic test_halt();
        sb_t  e;
        out_t v;
        int   n = 0;
        add(0, 1, I_HALT, 0, 0, 0, o_fetch(1), care_all);
        add(0, 0, '0, 0, 0, 0, o_none(), care_all);
        add(0, 0, '0, 0, 0, 0, o_none(), care_all);
        v = '0; v.halted = 1'b1;
        for (int i = 0; i < 3; i++)
            add(0, 1, I_JMP, 1, 1, 1, v, care_all);
        while (plan_q.size() > 0) begin
            apply(plan_q.pop_front());
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ((outs & e.care) !== (e.val & e.care)) begin
                errors++;
                $display("FAIL test_halt step %0d: outputs %h required %h (mask %h)", n, outs, e.val, e.care);
            end
            @(posedge clock); #1;
            n++;
        end
        $display("test_halt: %0d cycles checked", n);
    endtask

    initial begin
        care_all = '1;
        care_ex  = '1;
        care_ex.sel_r2 = 1'b0;
        care_wb  = '1;
        care_wb.alu_fn = 3'b000;
        care_wb.sh_ro_fn = 2'b00;
        care_wb.sel_alu_arg = 1'b0;
        care_wb.sel_r2 = 1'b0;
        test_reset();
        test_alu_shift();
        test_mem();
        test_branch();
        test_jsr_ret();
        test_fetch_wait_limit();
        test_mem_timeout();
        test_illegal();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
